seq_restoring_divider_16bit: RTL
================================

// Module: seq_restoring_divider_16bit
// PURPOSE
//  Multi-cycle restoring divider. It is the inverse datapath to the 16-bit carry-lookahead adder
//  and multiplier chain in the matrix unit, and is used for normalisation/averaging of results.
//  Accepts one dividend/divisor pair per start handshake and produces one quotient bit per clock.
//  Quotient, remainder and a divide-by-zero flag are presented with a single-cycle valid pulse.
// PARAMETERS
//  DATA_WIDTH  8   half operand width; operand/result width W = 2*DATA_WIDTH (16 by default)
// PORTS
//  clk           in   1  single clock, all state updates on rising edge
//  rst_n         in   1  synchronous reset, active-low
//  start         in   1  request; sampled only when ready=1
//  inData_A      in   W  dividend, captured on the accepted start edge
//  inData_B      in   W  divisor, captured on the accepted start edge
//  ready         out  1  1 only in IDLE
//  outQuot       out  W  quotient
//  outRem        out  W  remainder
//  valid         out  1  one-cycle pulse: outQuot/outRem/div_by_zero are new
//  div_by_zero   out  1  set with valid when captured divisor == 0
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, ready=1, valid=0, div_by_zero=0, outQuot=0, outRem=0, counter=0.
//  Reset mid-operation aborts the division; no valid is produced for the aborted operation.
//  FSM states:
//   IDLE -> CALC on start&ready with divisor!=0. Captures operands; partial remainder R=0; count=0.
//   IDLE -> DONE on start&ready with divisor==0.
//   CALC: each cycle R' = {R[W-2:0], A[msb]}; A shifts left 1.
//     If R' >= B: R = R'-B and the quotient bit = 1. Otherwise R = R' (restore) and the bit = 0.
//     Uses a (W+1)-bit trial subtract so the borrow is the compare.
//     After W iterations (count==W-1) -> DONE.
//   DONE: one cycle, valid=1, then -> IDLE unconditionally.
//  Latency: start sampled at edge E0. valid=1 in the cycle after edge E0+W+1 (17 for W=16).
//   Divide-by-zero: valid=1 after edge E0+1.
//  Divide-by-zero result: outQuot = all ones, outRem = dividend, div_by_zero=1.
//  outQuot/outRem/div_by_zero are registered and hold their values until the next DONE.
//   They are not cleared when a new start is accepted.
//  start while ready=0 (CALC/DONE) is ignored; the operand inputs are don't-care outside the accepted edge.
//  Back-to-back: a new start is accepted in the IDLE cycle right after DONE.
//   Minimum issue interval is W+2 cycles.
//  Boundaries: dividend < divisor -> q=0, r=dividend. Divisor=1 -> q=dividend, r=0.
//   Dividend=0 -> q=0, r=0. No overflow in unsigned mode.
// CONFIGURATION
//  DIV_SIGNED_EN defined:
//   Operands are two's complement. Magnitudes are divided with the same W-iteration core.
//   Quotient is negated if the operand signs differ; it truncates toward zero.
//   Remainder takes the sign of the dividend.
//   Sign fix-up adds one DONE-entry cycle, so latency = W+2.
//   Overflow (-2^(W-1) / -1): q = 0x8000 (W=16), r=0, div_by_zero=0.
//   Divide-by-zero: q = all ones (-1), r = dividend.
//  DIV_SIGNED_EN undefined: purely unsigned; no sign logic is synthesised; latency = W+1.
// TESTING
//  1. rst_n=0 for 2 cycles -> ready=1, valid=0, outQuot=0, outRem=0, div_by_zero=0.
//  2. A=1000, B=7 -> valid after 17 edges, q=142, r=6, dbz=0; ready low for 17 cycles.
//  3. A=3, B=10 -> q=0, r=3. A=0xFFFF, B=1 -> q=0xFFFF, r=0.
//  4. A=5, B=0 -> valid after 1 edge, q=0xFFFF, r=5, dbz=1.
//  5. start pulses during CALC with other operands -> ignored; result matches the first pair.
//     rst_n=0 at iteration 8 -> no valid, IDLE.
//  6. DIV_SIGNED_EN: -7/2 -> q=-3 (0xFFFD), r=-1 (0xFFFF).
//     0x8000/0xFFFF -> q=0x8000, r=0.
//     Then 1000 random pairs checked against a $signed / and % reference model.

Source files
------------

// File: rtl/seq_restoring_divider_16bit.sv
// Multi-cycle restoring divider: one quotient bit per clock, registered results with a valid pulse.
// Define DIV_SIGNED_EN for two's-complement operands (adds a sign fix-up cycle).
module seq_restoring_divider_16bit #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [2*DATA_WIDTH-1:0]   inData_A,
  input  logic [2*DATA_WIDTH-1:0]   inData_B,
  output logic                      ready,
  output logic [2*DATA_WIDTH-1:0]   outQuot,
  output logic [2*DATA_WIDTH-1:0]   outRem,
  output logic                      valid,
  output logic                      div_by_zero
);

  localparam int W  = 2 * DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    a_q;       // dividend shifting out, quotient bits shifting in
  logic [W-1:0]    b_q;
  logic [W-1:0]    r_q;
  logic            dbz_q;
  logic [W-1:0]    quot_q;
  logic [W-1:0]    rem_q;
  logic            dbz_out_q;
  logic            valid_q;

  logic            b_zero;
  logic [W-1:0]    a_load;
  logic [W-1:0]    b_load;
  logic [W-1:0]    r_shift;
  logic [W:0]      trial;
  logic            borrow;

`ifdef DIV_SIGNED_EN
  logic            q_neg_q;
  logic            r_neg_q;

  // Divide magnitudes; a zero divisor keeps the raw dividend for the remainder output.
  assign b_zero = (inData_B == '0);
  assign b_load = inData_B[W-1] ? -inData_B : inData_B;
  assign a_load = (inData_A[W-1] && !b_zero) ? -inData_A : inData_A;
`else
  assign b_zero = (inData_B == '0);
  assign b_load = inData_B;
  assign a_load = inData_A;
`endif

  // R only reaches W-1 significant bits within W iterations, so the dropped MSB is always zero.
  assign r_shift = {r_q[W-2:0], a_q[W-1]};
  assign trial   = {1'b0, r_shift} - {1'b0, b_q};
  assign borrow  = trial[W];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch and uses <= like all state.
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = b_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (cnt_q == CW'(W - 1)) begin
`ifdef DIV_SIGNED_EN
          state_d = S_FIX;
`else
          state_d = S_DONE;
`endif
        end
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    ready       = (state_q == S_IDLE);
    valid       = valid_q;
    outQuot     = quot_q;
    outRem      = rem_q;
    div_by_zero = dbz_out_q;
  end

  // Datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      dbz_q     <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_out_q <= 1'b0;
      valid_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
`endif
    end else begin
      valid_q <= (state_q == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q <= '0;
            a_q   <= a_load;
            b_q   <= b_load;
            r_q   <= '0;
            dbz_q <= b_zero;
`ifdef DIV_SIGNED_EN
            q_neg_q <= inData_A[W-1] ^ inData_B[W-1];
            r_neg_q <= inData_A[W-1];
`endif
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          a_q   <= {a_q[W-2:0], ~borrow};
          r_q   <= borrow ? r_shift : trial[W-1:0];
        end
`ifdef DIV_SIGNED_EN
        S_FIX: begin
          if (q_neg_q) a_q <= -a_q;
          if (r_neg_q) r_q <= -r_q;
        end
`endif
        S_DONE: begin
          quot_q    <= dbz_q ? '1 : a_q;
          rem_q     <= dbz_q ? a_q : r_q;
          dbz_out_q <= dbz_q;
        end
        default: ;
      endcase
    end
  end

endmodule
